// File: rtl/fp32_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency fp32 multiplier among NREQ requesters.
// A valid/tag pipeline tracks in-flight ops; results land in one-entry response buffers.
module fp32_mul_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TAGW    = 2,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [3*NREQ-1:0]    req_rm,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [32*NREQ-1:0]   rsp_result,
    output logic [4*NREQ-1:0]    rsp_flags,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    output logic [2:0]           mul_rm,
    input  logic [31:0]          mul_result,
    input  logic                 mul_nv,
    input  logic                 mul_of,
    input  logic                 mul_uf,
    input  logic                 mul_nx,
    output logic                 busy
);

    logic [NREQ-1:0]     owned_q;
    logic [TAGW-1:0]     ptr_q;
    logic [MUL_LAT:0]    vld_q;
    logic [TAGW-1:0]     tag_q [MUL_LAT+1];
    logic [31:0]         mul_a_q;
    logic [31:0]         mul_b_q;
    logic [2:0]          mul_rm_q;
    logic [NREQ-1:0]     rsp_valid_q;
    logic [32*NREQ-1:0]  rsp_result_q;
    logic [4*NREQ-1:0]   rsp_flags_q;

    logic [NREQ-1:0]     eligible;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     drain;
    logic                found;
    logic [TAGW-1:0]     win;
    logic [TAGW-1:0]     idx;
    logic [31:0]         sel_a;
    logic [31:0]         sel_b;
    logic [2:0]          sel_rm;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        eligible = req_valid & ~owned_q;
        grant    = '0;
        found    = 1'b0;
        win      = ptr_q;
        idx      = ptr_q;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = TAGW'((32'(ptr_q) + k) % NREQ);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) begin
            grant[win] = 1'b1;
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_rm = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_rm = req_rm[3*i +: 3];
            end
        end
    end

    assign drain = rsp_valid_q & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owned_q      <= '0;
            ptr_q        <= TAGW'(NREQ - 1);
            vld_q        <= '0;
            for (int s = 0; s <= MUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_rm_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            owned_q <= (owned_q | grant) & ~drain;
            if (found) begin
                ptr_q    <= win;
                mul_a_q  <= sel_a;
                mul_b_q  <= sel_b;
                mul_rm_q <= sel_rm;
            end
            vld_q    <= {vld_q[MUL_LAT-1:0], found};
            tag_q[0] <= win;
            for (int s = 1; s <= MUL_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            for (int i = 0; i < NREQ; i++) begin
                if (drain[i]) begin
                    rsp_valid_q[i]           <= 1'b0;
                    rsp_result_q[32*i +: 32] <= '0;
                    rsp_flags_q[4*i +: 4]    <= '0;
                end
                if (vld_q[MUL_LAT] && tag_q[MUL_LAT] == TAGW'(i)) begin
                    rsp_valid_q[i]           <= 1'b1;
                    rsp_result_q[32*i +: 32] <= mul_result;
                    rsp_flags_q[4*i +: 4]    <= {mul_nv, mul_of, mul_uf, mul_nx};
                end
            end
        end
    end

    assign req_ready  = grant;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_rm     = mul_rm_q;
    assign busy       = |owned_q;

    // Ownership keeps a buffer empty whenever its result lands.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        vld_q[MUL_LAT] |-> !rsp_valid_q[tag_q[MUL_LAT]]);
    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Bench for fp32_mul_arbiter: 3-stage multiplier stub, arbiter reference model and a
// scoreboard of expected responses checked on arrival.
module tb_fp32_mul_arbiter;

    localparam int NREQ = 4;
    localparam int T2_IDX [5] = '{0, 1, 2, 3, 0};
    localparam int T2_OFF [5] = '{0, 1, 2, 3, 6};

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [3*NREQ-1:0]   req_rm;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [32*NREQ-1:0]  rsp_result;
    logic [4*NREQ-1:0]   rsp_flags;
    logic [31:0]         mul_a;
    logic [31:0]         mul_b;
    logic [2:0]          mul_rm;
    logic [31:0]         mul_result;
    logic                mul_nv;
    logic                mul_of;
    logic                mul_uf;
    logic                mul_nx;
    logic                busy;

    fp32_mul_arbiter #(.NREQ(NREQ), .TAGW(2), .MUL_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .mul_a(mul_a), .mul_b(mul_b), .mul_rm(mul_rm),
        .mul_result(mul_result),
        .mul_nv(mul_nv), .mul_of(mul_of), .mul_uf(mul_uf), .mul_nx(mul_nx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in multiplier: known IEEE cases from a table, otherwise a deterministic hash.
    function automatic logic [35:0] mulf(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] rm);
        if (a == 32'h3FC00000 && b == 32'h40000000) return {4'b0000, 32'h40400000};
        if (a == 32'h7F800000 && b == 32'h00000000) return {4'b1000, 32'h7FC00000};
        if (a == 32'h7F000000 && b == 32'h7F000000)
            return (rm == 3'd1 || rm == 3'd2) ? {4'b0101, 32'h7F7FFFFF} : {4'b0101, 32'h7F800000};
        return {a[3:0] ^ b[7:4] ^ {1'b0, rm}, a ^ {b[15:0], b[31:16]} ^ {29'd0, rm}};
    endfunction

    logic [35:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= mulf(mul_a, mul_b, mul_rm);
        p2 <= p1;
        p3 <= p2;
    end
    assign {mul_nv, mul_of, mul_uf, mul_nx, mul_result} = p3;

    typedef struct { int idx; logic [35:0] d; int cyc; } e_t;
    typedef struct { int idx; int cyc; } g_t;
    e_t sb [$];
    g_t glog [$];

    int              n_pass = 0;
    int              n_total = 0;
    logic [NREQ-1:0] own_m = '0;
    int              ptr_m = NREQ - 1;
    logic [NREQ-1:0] seen = '0;
    logic [NREQ-1:0] hs = '0;
    logic [35:0]     held [NREQ];
    int              reps [NREQ];
    int              last_grant [NREQ];
    int              last_drain [NREQ];
    int              ngrant [NREQ];
    int              gsnap [NREQ];
    bit              rnd = 1'b0;
    int              base;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic post(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_rm[3*i +: 3]  = rm;
        req_valid[i]      = 1'b1;
    endtask

    // Sampled mid-cycle: arbiter reference, response scoreboard, handshake capture.
    task automatic observe();
        logic [NREQ-1:0] elig, exp_gnt, clr;
        int p, j;
        e_t e;
        elig = req_valid & ~own_m;
        exp_gnt = '0;
        clr = '0;
        for (int k = 1; k <= NREQ; k++) begin
            p = (ptr_m + k) % NREQ;
            if (exp_gnt == '0 && elig[p]) exp_gnt[p] = 1'b1;
        end
        chk("req_ready", req_ready, exp_gnt);
        chk("busy", busy, own_m != '0);
        for (int i = 0; i < NREQ; i++) begin
            if (rsp_valid[i]) begin
                if (!seen[i]) begin
                    j = -1;
                    foreach (sb[m]) if (j < 0 && sb[m].idx == i) j = m;
                    if (j < 0) begin
                        chk("rsp_unexpected", rsp_valid[i], 1'b0);
                    end else begin
                        e = sb[j];
                        sb.delete(j);
                        chk("rsp_result", rsp_result[32*i +: 32], e.d[31:0]);
                        chk("rsp_flags", rsp_flags[4*i +: 4], e.d[35:32]);
                        chk("rsp_latency", cyc - e.cyc, 5);
                        held[i] = {rsp_flags[4*i +: 4], rsp_result[32*i +: 32]};
                        seen[i] = 1'b1;
                    end
                end else begin
                    chk("rsp_hold", {rsp_flags[4*i +: 4], rsp_result[32*i +: 32]}, held[i]);
                end
                if (rsp_ready[i]) begin
                    seen[i] = 1'b0;
                    clr[i] = 1'b1;
                    last_drain[i] = cyc;
                end
            end else begin
                chk("rsp_idle_data", {rsp_flags[4*i +: 4], rsp_result[32*i +: 32]}, '0);
                if (seen[i]) begin
                    chk("rsp_dropped", rsp_valid[i], 1'b1);
                    seen[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                sb.push_back('{idx: i, cyc: cyc,
                               d: mulf(req_a[32*i +: 32], req_b[32*i +: 32], req_rm[3*i +: 3])});
                glog.push_back('{idx: i, cyc: cyc});
                own_m[i] = 1'b1;
                ptr_m = i;
                hs[i] = 1'b1;
                last_grant[i] = cyc;
                ngrant[i]++;
            end
        end
        own_m = own_m & ~clr;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                if (reps[i] > 0) reps[i]--;
                else req_valid[i] = 1'b0;
            end
            if (rnd) begin
                if (!req_valid[i] && $urandom_range(3, 0) == 0)
                    post(i, $urandom, $urandom, 3'($urandom_range(4, 0)));
                rsp_ready[i] = ($urandom_range(3, 0) != 0);
            end
        end
        hs = '0;
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((own_m != '0 || sb.size() != 0 || req_valid != '0) && n < bound) begin
            step();
            n++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_rm = '0;
        rsp_ready = '1;
        for (int i = 0; i < NREQ; i++) begin
            reps[i] = 0; last_grant[i] = -100; last_drain[i] = -100; ngrant[i] = 0;
            held[i] = '0;
        end
        #1;
        chk("rst_ctrl", {req_ready, rsp_valid, busy, mul_rm}, '0);
        chk("rst_mul_ab", {mul_a, mul_b}, '0);
        chk("rst_rsp_data", {rsp_flags, rsp_result}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All four request at once from reset; requester 0 keeps requesting.
        glog.delete();
        reps[0] = 1;
        post(0, 32'h3FC00000, 32'h40000000, 3'd0);
        for (int i = 1; i < NREQ; i++) post(i, $urandom, $urandom, 3'(i));
        base = cyc;
        repeat (12) step();
        chk("t2_ngrant", glog.size(), 5);
        for (int j = 0; j < 5; j++) begin
            if (j < glog.size()) begin
                chk("t2_grant_idx", glog[j].idx, T2_IDX[j]);
                chk("t2_grant_cyc", glog[j].cyc - base, T2_OFF[j]);
            end
        end
        wait_idle(40);

        // Single op held in its buffer.
        rsp_ready[0] = 1'b0;
        post(0, 32'h3FC00000, 32'h40000000, 3'd0);
        repeat (6) step();
        chk("t1_valid", rsp_valid[0], 1'b1);
        chk("t1_result", {rsp_flags[3:0], rsp_result[31:0]}, {4'b0000, 32'h40400000});
        rsp_ready[0] = 1'b1;
        wait_idle(20);

        // Backpressure on requester 1 while 0 and 2 keep issuing.
        rsp_ready[1] = 1'b0;
        reps[0] = 2; reps[1] = 1; reps[2] = 2;
        gsnap[0] = ngrant[0]; gsnap[2] = ngrant[2];
        post(1, $urandom, $urandom, 3'd1);
        post(0, $urandom, $urandom, 3'd2);
        post(2, $urandom, $urandom, 3'd3);
        repeat (20) step();
        chk("t3_grants0", ngrant[0] - gsnap[0], 3);
        chk("t3_grants2", ngrant[2] - gsnap[2], 3);
        chk("t3_rsp1_held", rsp_valid[1], 1'b1);
        rsp_ready[1] = 1'b1;
        repeat (3) step();
        chk("t3_regrant", last_grant[1] - last_drain[1], 1);
        wait_idle(30);

        // Special values passed through untouched.
        post(2, 32'h7F800000, 32'h00000000, 3'd0);
        post(3, 32'h7F000000, 32'h7F000000, 3'd1);
        post(0, 32'h7F000000, 32'h7F000000, 3'd0);
        wait_idle(30);

        // Fairness: 1 then 3 leaves the pointer at 3, so 1 wins the next tie.
        post(1, $urandom, $urandom, 3'd0);
        step();
        post(3, $urandom, $urandom, 3'd0);
        step();
        wait_idle(30);
        chk("t5_order", last_grant[3] - last_grant[1], 1);
        post(3, $urandom, $urandom, 3'd4);
        post(1, $urandom, $urandom, 3'd4);
        step();
        chk("t5_rr_first", glog[glog.size()-1].idx, 1);
        wait_idle(30);

        // Random traffic with random response backpressure.
        for (int i = 0; i < NREQ; i++) gsnap[i] = ngrant[i];
        rnd = 1'b1;
        repeat (1000) step();
        rnd = 1'b0;
        rsp_ready = '1;
        wait_idle(100);
        for (int i = 0; i < NREQ; i++) chk("rand_no_starve", ngrant[i] > gsnap[i], 1'b1);

        // Asynchronous reset with two ops in flight.
        post(0, $urandom, $urandom, 3'd0);
        post(1, $urandom, $urandom, 3'd0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rstmid_ctrl", {req_ready, rsp_valid, busy, mul_rm}, '0);
        chk("rstmid_mul_ab", {mul_a, mul_b}, '0);
        chk("rstmid_rsp_data", {rsp_flags, rsp_result}, '0);
        sb.delete();
        own_m = '0;
        seen = '0;
        hs = '0;
        ptr_m = NREQ - 1;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) step();
        post(2, 32'h3FC00000, 32'h40000000, 3'd0);
        wait_idle(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp32_mul_arbiter.md
Name: fp32_mul_arbiter

Overview:
Shares one pipelined fp32_mul datapath (fixed 3-cycle latency, no enable or stall) between NREQ requesters, each with its own valid/ready request and response channels. A round-robin arbiter issues at most one multiply per cycle. A valid/tag shift pipeline tracks in-flight operations. Results and flags go to per-requester one-entry response buffers. The block sits between the core/issue logic and the shared multiplier instance.

Parameters:
NREQ, 4, number of requesters (2..8)
TAGW, 2, requester-index width, equal to clog2(NREQ)
MUL_LAT, 3, multiplier latency in clock edges from operand inputs to registered result; must match the multiplier

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester grant; at most one bit set
req_a  input  32*NREQ  operand a, requester i at [32i+31:32i]
req_b  input  32*NREQ  operand b, same packing as req_a
req_rm  input  3*NREQ  rounding mode, RNE=0 RTZ=1 RDN=2 RUP=3 RMM=4
rsp_valid  output  NREQ  response buffer i full
rsp_ready  input  NREQ  requester i accepts its response
rsp_result  output  32*NREQ  product per requester
rsp_flags  output  4*NREQ  {nv,of,uf,nx} per requester
mul_a  output  32  registered operand a to multiplier
mul_b  output  32  registered operand b to multiplier
mul_rm  output  3  registered rounding mode to multiplier
mul_result  input  32  multiplier result
mul_nv, mul_of, mul_uf, mul_nx  input  1 each  multiplier flags
busy  output  1  high if any op is in flight or any response buffer is full

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, mul_a=0, mul_b=0, mul_rm=0, busy=0. All tag-pipeline valid bits are 0. owned[]=0. RR pointer=NREQ-1, so requester 0 has top priority first.
- Eligibility: eligible[i] = req_valid[i] & ~owned[i]. owned[i] is a register. It sets on the request handshake and clears on the response handshake (rsp_valid[i] & rsp_ready[i]). Each requester therefore has at most one op outstanding, from issue until its response drains.
- Arbitration: combinational. Search starts at pointer+1 and wraps modulo NREQ. The first eligible requester gets req_ready. The pointer updates to the winner only on a grant. If no requester is eligible, there is no grant and the pointer holds.
- An owned requester never gets req_ready, even if req_valid is high and its response drains in the same cycle. It becomes eligible the following cycle.
- Issue, cycle c (handshake): at the edge ending cycle c, register mul_a/mul_b/mul_rm from the winner and set the issue-stage valid bit with tag=winner. With no grant, operands hold their old values and the valid bit is 0.
- Tag pipeline: the issue valid/tag enter a MUL_LAT-deep shift register. The output stage is aligned with mul_result in cycle c+1+MUL_LAT.
- Capture: at the end of cycle c+4, the output-stage tag writes mul_result and flags into buffer[tag]. rsp_valid[tag]=1 in cycle c+5. End-to-end latency is 5 cycles.
- Buffers cannot overflow, because of the ownership rule. A capture into a full buffer is impossible; it is an assertion failure.
- Response: rsp_valid[i] and data hold stable until rsp_ready[i]. They clear at the edge after the handshake. Capture for another requester in the same cycle is independent.
- Throughput: one grant per cycle across requesters. Back-to-back grants to different requesters fill the pipeline fully.
- rsp_result and flags are passed through unmodified, e.g. NaN 0x7FC00000 with nv, overflow saturation per rm.
- Reset mid-operation: all in-flight ops and buffered responses are discarded. Stale multiplier outputs are ignored because the tag-pipeline valid bits are 0.
- busy = |owned.

Test Plan:
- Single op: requester 0, a=0x3FC00000, b=0x40000000, rm=0, handshake in cycle 0 -> rsp_valid[0]=1 in cycle 5, result 0x40400000, flags 4'b0000.
- All four req_valid high from cycle 0, rsp_ready=1 -> grants in order 0,1,2,3 in cycles 0-3. Responses arrive in cycles 5-8. Requester 0 is re-granted in cycle 6, after its cycle-5 drain clears owned.
- Backpressure: rsp_ready[1]=0 for 20 cycles -> rsp_valid[1] and result held stable, req_ready[1]=0 throughout. Other requesters are granted normally. Requester 1 is re-granted in the cycle after the drain.
- Invalid: 0x7F800000 * 0x00000000 -> 0x7FC00000, flags 4'b1000. Overflow: 0x7F000000 * 0x7F000000, rm=1 -> 0x7F7FFFFF, flags 4'b0101. Same operands with rm=0 -> 0x7F800000, flags 4'b0101.
- Fairness: requesters 1 and 3 are granted; a response drains, then requesters 3 and 1 request again with the pointer at 3 -> requester 1 is granted first. No starvation over 1000 random cycles (scoreboard).
- Reset: rst_n low in cycle 2 with two ops in flight -> all outputs 0 immediately (asynchronous). After release, no rsp_valid for 10 cycles. A new op completes with correct 5-cycle latency.
